pc_sequencer: RTL and testbench

Program-counter sequencer for the micro-processor fetch path. It drives the select of the program-memory 2:1 address mux, with d0 = PC+1 and d1 = jump/call/return target, and registers the mux result as the new PC. It runs a two-cycle FETCH/EXEC loop and supports unconditional jump, jump-if-zero, call/return through a small hardware return stack, halt, and stall.

---
 rtl/pc_sequencer.sv | 123 ++++++++++++
 tb/tb_pc_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: two-cycle FETCH/EXEC loop driving the program-memory
// address mux, with jump, jump-if-zero, call/return via a hardware stack, halt and stall.
module pc_sequencer #(
   parameter int AW    = 4,
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          run,
   input  logic          stall,
   input  logic          jmp,
   input  logic          jz,
   input  logic          zero_flag,
   input  logic          call,
   input  logic          ret,
   input  logic          halt,
   input  logic [AW-1:0] tgt_addr,
   output logic [AW-1:0] pc,
   output logic          pm_sel,
   output logic [AW-1:0] mux_d1,
   output logic          fetch_en,
   output logic          running,
   output logic          stk_ovf,
   output logic          stk_unf
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] SP_ONE  = (PW+1)'(1);
   localparam logic [PW:0] SP_FULL = (PW+1)'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

   state_t        state_q;
   logic [AW-1:0] pc_q, pc_d, pc_inc;
   logic [PW:0]   sp_q, sp_d;
   logic [AW-1:0] stk_q [DEPTH];
   logic          ovf_q, unf_q;
   logic          push, ovf_set, unf_set;
   logic          exec_go, stk_full, stk_empty;
   logic [PW-1:0] top_idx, wr_idx;

   assign pc_inc    = pc_q + AW'(1);
   assign exec_go   = (state_q == S_EXEC) && !stall && !reset;
   assign stk_full  = (sp_q == SP_FULL);
   assign stk_empty = (sp_q == '0);
   assign top_idx   = PW'(sp_q - SP_ONE);
   assign wr_idx    = sp_q[PW-1:0];

   // EXEC decision: halt > ret > call > jmp/jz > sequential
   always_comb begin
      pm_sel  = 1'b0;
      mux_d1  = '0;
      pc_d    = pc_q;
      sp_d    = sp_q;
      push    = 1'b0;
      ovf_set = 1'b0;
      unf_set = 1'b0;
      if (exec_go && !halt) begin
         if (ret) begin
            if (!stk_empty) begin
               pm_sel = 1'b1;
               mux_d1 = stk_q[top_idx];
               pc_d   = stk_q[top_idx];
               sp_d   = sp_q - SP_ONE;
            end else begin
               unf_set = 1'b1;
               pc_d    = pc_inc;
            end
         end else if (call) begin
            if (!stk_full) begin
               push   = 1'b1;
               pm_sel = 1'b1;
               mux_d1 = tgt_addr;
               pc_d   = tgt_addr;
               sp_d   = sp_q + SP_ONE;
            end else begin
               ovf_set = 1'b1;
               pc_d    = pc_inc;
            end
         end else if (jmp || (jz && zero_flag)) begin
            pm_sel = 1'b1;
            mux_d1 = tgt_addr;
            pc_d   = tgt_addr;
         end else begin
            pc_d = pc_inc;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         sp_q    <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else if (!stall) begin
         pc_q <= pc_d;
         sp_q <= sp_d;
         if (ovf_set) ovf_q <= 1'b1;
         if (unf_set) unf_q <= 1'b1;
         case (state_q)
            S_IDLE:  if (run) state_q <= S_FETCH;
            S_FETCH: state_q <= S_EXEC;
            S_EXEC:  state_q <= halt ? S_HALT : S_FETCH;
            S_HALT:  if (run) state_q <= S_FETCH;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Stack contents need no reset; the pointer alone defines validity
   always_ff @(posedge clk) begin
      if (push) stk_q[wr_idx] <= pc_inc;
   end

   assign pc       = pc_q;
   assign fetch_en = (state_q == S_FETCH);
   assign running  = (state_q == S_FETCH) || (state_q == S_EXEC);
   assign stk_ovf  = ovf_q;
   assign stk_unf  = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, hand-written corner sequences and
// randomized traffic, all checked against a queue-based reference model.
module tb_pc_sequencer;
   localparam int AW = 4;
   localparam int DEPTH = 4;
   localparam int MOD = 1 << AW;
   localparam int M_IDLE = 0, M_FETCH = 1, M_EXEC = 2, M_HALT = 3;

   logic clk = 1'b0;
   logic reset, run, stall, jmp, jz, zero_flag, call, ret, halt;
   logic [AW-1:0] tgt_addr, pc, mux_d1;
   logic pm_sel, fetch_en, running, stk_ovf, stk_unf;

   int tests = 0;
   int fails = 0;

   int m_st, m_pc;
   int m_stk[$];
   logic m_ovf, m_unf;

   typedef struct {
      logic j, z, zf, c, r, h;
      logic [AW-1:0] t;
      logic sel;
      logic [AW-1:0] d1;
      logic [AW-1:0] pc_after;
   } vec_t;
   vec_t tbl[11];

   pc_sequencer #(.AW(AW), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .run(run), .stall(stall), .jmp(jmp), .jz(jz),
      .zero_flag(zero_flag), .call(call), .ret(ret), .halt(halt), .tgt_addr(tgt_addr),
      .pc(pc), .pm_sel(pm_sel), .mux_d1(mux_d1), .fetch_en(fetch_en),
      .running(running), .stk_ovf(stk_ovf), .stk_unf(stk_unf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic model_edge();
      if (reset) begin
         m_st = M_IDLE; m_pc = 0; m_stk.delete(); m_ovf = 0; m_unf = 0;
      end else if (!stall) begin
         case (m_st)
            M_IDLE:  if (run) m_st = M_FETCH;
            M_FETCH: m_st = M_EXEC;
            M_HALT:  if (run) m_st = M_FETCH;
            default: begin
               if (halt) m_st = M_HALT;
               else begin
                  m_st = M_FETCH;
                  if (ret) begin
                     if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                     else begin m_unf = 1; m_pc = (m_pc + 1) % MOD; end
                  end else if (call) begin
                     if (m_stk.size() < DEPTH) begin
                        m_stk.push_back((m_pc + 1) % MOD); m_pc = int'(tgt_addr);
                     end else begin m_ovf = 1; m_pc = (m_pc + 1) % MOD; end
                  end else if (jmp || (jz && zero_flag)) m_pc = int'(tgt_addr);
                  else m_pc = (m_pc + 1) % MOD;
               end
            end
         endcase
      end
   endtask

   // One clock: check mux outputs for current inputs, advance, check registered outputs
   task automatic step();
      logic exp_sel;
      int exp_d1;
      #1;
      exp_sel = 0; exp_d1 = 0;
      if (m_st == M_EXEC && !stall && !reset && !halt) begin
         if (ret) begin
            if (m_stk.size() > 0) begin exp_sel = 1; exp_d1 = m_stk[$]; end
         end else if (call) begin
            if (m_stk.size() < DEPTH) begin exp_sel = 1; exp_d1 = int'(tgt_addr); end
         end else if (jmp || (jz && zero_flag)) begin
            exp_sel = 1; exp_d1 = int'(tgt_addr);
         end
      end
      chk("pm_sel", pm_sel, exp_sel);
      chk("mux_d1", mux_d1, exp_d1);
      @(posedge clk);
      model_edge();
      #1;
      chk("pc", pc, m_pc);
      chk("fetch_en", fetch_en, m_st == M_FETCH);
      chk("running", running, m_st == M_FETCH || m_st == M_EXEC);
      chk("stk_ovf", stk_ovf, m_ovf);
      chk("stk_unf", stk_unf, m_unf);
   endtask

   task automatic clr_ctrl();
      jmp = 0; jz = 0; zero_flag = 0; call = 0; ret = 0; halt = 0; tgt_addr = '0;
   endtask

   task automatic reset_and_run();
      clr_ctrl(); stall = 0; run = 0;
      reset = 1; step(); step();
      reset = 0; run = 1; step(); run = 0;
   endtask

   // One FETCH+EXEC pair; returns mux outputs seen during EXEC
   task automatic instr(input logic j, z, zf, c, r, h, input logic [AW-1:0] t,
                        output logic sel, output logic [AW-1:0] d1);
      clr_ctrl(); step();
      jmp = j; jz = z; zero_flag = zf; call = c; ret = r; halt = h; tgt_addr = t;
      #1; sel = pm_sel; d1 = mux_d1;
      step();
      clr_ctrl();
   endtask

   initial begin
      logic s;
      logic [AW-1:0] d;
      logic [AW-1:0] pc_hold;
      int exp_ret[4];

      tbl[0]  = '{0,0,0,0,0,0,4'd0, 0,4'd0, 4'd1};
      tbl[1]  = '{0,0,0,0,0,0,4'd0, 0,4'd0, 4'd2};
      tbl[2]  = '{0,0,0,0,0,0,4'd0, 0,4'd0, 4'd3};
      tbl[3]  = '{1,0,0,0,0,0,4'd9, 1,4'd9, 4'd9};
      tbl[4]  = '{0,1,0,0,0,0,4'd4, 0,4'd0, 4'd10};
      tbl[5]  = '{0,1,1,0,0,0,4'd2, 1,4'd2, 4'd2};
      tbl[6]  = '{0,0,0,0,0,0,4'd0, 0,4'd0, 4'd3};
      tbl[7]  = '{0,0,0,0,0,0,4'd0, 0,4'd0, 4'd4};
      tbl[8]  = '{0,0,0,0,0,0,4'd0, 0,4'd0, 4'd5};
      tbl[9]  = '{0,0,0,1,0,0,4'd12,1,4'd12,4'd12};
      tbl[10] = '{0,0,0,0,1,0,4'd0, 1,4'd6, 4'd6};

      m_st = M_IDLE; m_pc = 0; m_ovf = 0; m_unf = 0;
      clr_ctrl(); stall = 0; run = 0; reset = 1;
      step(); step();
      chk("rst_pc", pc, 0);
      chk("rst_fetch_en", fetch_en, 0);
      chk("rst_running", running, 0);
      chk("rst_pm_sel", pm_sel, 0);
      chk("rst_mux_d1", mux_d1, 0);
      chk("rst_flags", {stk_ovf, stk_unf}, 0);
      reset = 0; run = 1; step(); run = 0;

      // Free-running sequence with wrap
      for (int i = 0; i < 17; i++) begin
         chk("seq_fetch_en", fetch_en, 1);
         instr(0,0,0,0,0,0,'0, s, d);
         chk("seq_pm_sel", s, 0);
         chk("seq_pc", pc, (i + 1) % MOD);
      end

      // Directed vector table
      reset_and_run();
      for (int i = 0; i < 11; i++) begin
         instr(tbl[i].j, tbl[i].z, tbl[i].zf, tbl[i].c, tbl[i].r, tbl[i].h, tbl[i].t, s, d);
         chk($sformatf("tbl%0d_sel", i), s, tbl[i].sel);
         chk($sformatf("tbl%0d_d1", i), d, tbl[i].d1);
         chk($sformatf("tbl%0d_pc", i), pc, tbl[i].pc_after);
      end

      // Nested calls, overflow, returns, underflow
      reset_and_run();
      instr(0,0,0,1,0,0,4'd4, s, d);  chk("call1_pc", pc, 4);
      instr(0,0,0,1,0,0,4'd8, s, d);  chk("call2_pc", pc, 8);
      instr(0,0,0,1,0,0,4'd12, s, d); chk("call3_pc", pc, 12);
      instr(0,0,0,1,0,0,4'd14, s, d); chk("call4_pc", pc, 14);
      chk("call4_ovf", stk_ovf, 0);
      instr(0,0,0,1,0,0,4'd2, s, d);
      chk("call5_sel", s, 0);
      chk("call5_ovf", stk_ovf, 1);
      chk("call5_pc", pc, 15);
      exp_ret = '{13, 9, 5, 1};
      for (int i = 0; i < 4; i++) begin
         instr(0,0,0,0,1,0,'0, s, d);
         chk("ret_pc", pc, exp_ret[i]);
         chk("ret_d1", d, exp_ret[i]);
      end
      instr(0,0,0,0,1,0,'0, s, d);
      chk("unf_sel", s, 0);
      chk("unf_flag", stk_unf, 1);
      chk("unf_pc", pc, 2);
      instr(0,0,0,0,0,0,'0, s, d);
      chk("sticky_flags", {stk_ovf, stk_unf}, 2'b11);

      // Halt and resume
      instr(1,0,0,0,0,0,4'd7, s, d);
      instr(0,0,0,0,0,1,'0, s, d);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("halt_pc", pc, 7);
         chk("halt_state", {fetch_en, running}, 2'b00);
      end
      run = 1; step(); run = 0;
      chk("resume_fetch", fetch_en, 1);
      chk("resume_pc", pc, 7);

      // Stall held mid-EXEC with jmp pending
      clr_ctrl(); step();
      pc_hold = pc;
      jmp = 1; tgt_addr = 4'd13; stall = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_pc", pc, pc_hold);
         chk("stall_state", {fetch_en, running}, 2'b01);
      end
      stall = 0; jmp = 0;
      step();
      chk("post_stall_pc", pc, (int'(pc_hold) + 1) % MOD);

      // Reset mid-EXEC with two stacked entries
      instr(0,0,0,1,0,0,4'd3, s, d);
      instr(0,0,0,1,0,0,4'd6, s, d);
      clr_ctrl(); step();
      jmp = 1; tgt_addr = 4'd11; reset = 1;
      step();
      chk("rst_mid_pc", pc, 0);
      chk("rst_mid_state", {fetch_en, running}, 2'b00);
      chk("rst_mid_flags", {stk_ovf, stk_unf}, 2'b00);
      reset = 0; clr_ctrl(); run = 1; step(); run = 0;
      instr(0,0,0,0,1,0,'0, s, d);
      chk("rst_stack_empty", stk_unf, 1);
      chk("rst_stack_pc", pc, 1);

      // Randomized traffic against the model
      reset_and_run();
      for (int i = 0; i < 3000; i++) begin
         reset     = ($urandom_range(0, 199) == 0);
         run       = ($urandom_range(0, 3) == 0);
         stall     = ($urandom_range(0, 7) == 0);
         jmp       = ($urandom_range(0, 5) == 0);
         jz        = ($urandom_range(0, 4) == 0);
         zero_flag = 1'($urandom_range(0, 1));
         call      = ($urandom_range(0, 4) == 0);
         ret       = ($urandom_range(0, 4) == 0);
         halt      = ($urandom_range(0, 15) == 0);
         tgt_addr  = AW'($urandom_range(0, MOD - 1));
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
